mmio_console: RTL and testbench

//  Memory-mapped console/exit device on the core's data-memory write port, placed in front of dmem.

---
 rtl/mmio_console_pkg.sv | 14 +
 rtl/mmio_console_sync_fifo.sv | 48 ++++
 rtl/mmio_console.sv | 120 ++++++++++++
 tb/tb_mmio_console.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_console_pkg.sv
// Shared constants and FSM encoding for the MMIO console/exit device.
package mmio_console_pkg;

  localparam int          DEF_DEPTH     = 16;
  localparam logic [31:0] DEF_PUTC_ADDR = 32'h9000_001c;
  localparam logic [31:0] DEF_EXIT_ADDR = 32'h9000_002c;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty/count status.
module mmio_console_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full from empty; subtraction wraps naturally.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full with a pop, the write lands in the slot being vacated this cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_console.sv
// Console/exit MMIO device in front of dmem: buffers PUTC bytes into a byte
// stream and reports exit once every buffered byte has been delivered.
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter int          DEPTH     = DEF_DEPTH,
  parameter logic [31:0] PUTC_ADDR = DEF_PUTC_ADDR,
  parameter logic [31:0] EXIT_ADDR = DEF_EXIT_ADDR
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        dmem_wready,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        ram_wready,
  output logic        stall_req,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        exit_valid,
  output logic [31:0] exit_code,
  output logic [15:0] overflow_cnt,
  output logic [1:0]  fsm_state
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - 2);

  state_t      state_q;
  state_t      state_next;
  logic        is_putc;
  logic        is_exit;
  logic        putc_req;
  logic        push_ok;
  logic        pop;
  logic        drop;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic [AW:0] count_next;
  logic [7:0]  head;
  logic        stall_q;
  logic [31:0] exit_code_q;
  logic [15:0] ovf_q;
  logic        unused_strb;

  assign unused_strb = &{1'b0, dmem_wstrb[3:1]};

  assign is_putc  = dmem_wready && (dmem_waddr == PUTC_ADDR);
  assign is_exit  = dmem_wready && (dmem_waddr == EXIT_ADDR);
  assign putc_req = is_putc && dmem_wstrb[0] && (state_q == ST_RUN);

  // tx stream: valid/ready; a byte transfers on a cycle where both are high,
  // and tx_data holds while valid is high and ready is low.
  assign pop     = !empty && tx_ready;
  assign push_ok = putc_req && (!full || pop);
  assign drop    = putc_req && !push_ok;

  assign count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop);

  mmio_console_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .push      (push_ok),
    .push_data (dmem_wdata[7:0]),
    .pop       (pop),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_next = state_q;
    ram_wready = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        ram_wready = dmem_wready && !is_putc && !is_exit;
        if (is_exit) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty && !pop) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_RUN;
      stall_q     <= 1'b0;
      exit_code_q <= '0;
      ovf_q       <= '0;
    end else begin
      state_q <= state_next;
      // The core is held for good once an exit has been written.
      stall_q <= (state_next != ST_RUN) || (count_next >= STALL_LVL);
      if ((state_q == ST_RUN) && is_exit) exit_code_q <= dmem_wdata;
      if (drop && (ovf_q != 16'hffff)) ovf_q <= ovf_q + 16'd1;
    end
  end

  assign stall_req    = stall_q;
  assign tx_valid     = !empty;
  assign tx_data      = head;
  assign exit_valid   = (state_q == ST_DONE);
  assign exit_code    = exit_code_q;
  assign overflow_cnt = ovf_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: decode table plus multi-cycle sequences.
module tb_mmio_console;
  import mmio_console_pkg::*;

  localparam logic [31:0] PUTC = 32'h9000_001c;
  localparam logic [31:0] EXIT = 32'h9000_002c;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        dmem_wready;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        ram_wready;
  logic        stall_req;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        exit_valid;
  logic [31:0] exit_code;
  logic [15:0] overflow_cnt;
  logic [1:0]  fsm_state;

  mmio_console #(.DEPTH(16)) dut (
    .clk          (clk),
    .resetb       (resetb),
    .dmem_wready  (dmem_wready),
    .dmem_waddr   (dmem_waddr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .ram_wready   (ram_wready),
    .stall_req    (stall_req),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .exit_valid   (exit_valid),
    .exit_code    (exit_code),
    .overflow_cnt (overflow_cnt),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        exp_ram;
    logic        exp_tx;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    dmem_wready = 1'b0;
    dmem_waddr  = '0;
    dmem_wdata  = '0;
    dmem_wstrb  = '0;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dmem_wready = 1'b1;
    dmem_waddr  = a;
    dmem_wdata  = d;
    dmem_wstrb  = s;
  endtask

  task automatic do_reset();
    idle_bus();
    tx_ready = 1'b0;
    resetb   = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " tx_valid"}, tx_valid, 0);
    check({tag, " tx_data"}, tx_data, 0);
    check({tag, " stall_req"}, stall_req, 0);
    check({tag, " exit_valid"}, exit_valid, 0);
    check({tag, " exit_code"}, exit_code, 0);
    check({tag, " overflow_cnt"}, overflow_cnt, 0);
    check({tag, " fsm_state"}, fsm_state, 0);
    check({tag, " ram_wready"}, ram_wready, 0);
  endtask

  // Scoreboard drain: tx_ready must already be high.
  task automatic drain_expect(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      if (tx_valid) check(name, tx_data, exp_q.pop_front());
      tick();
      guard++;
    end
    check({name, " leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"putc_H",    PUTC,           32'h0000_0048, 4'b0001, 1'b0, 1'b1, 8'h48};
    vecs[1] = '{"putc_full", PUTC,           32'h0000_0069, 4'b1111, 1'b0, 1'b1, 8'h69};
    vecs[2] = '{"ram_write", 32'h0002_0000,  32'h0000_1234, 4'b1111, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{"putc_nob0", PUTC,           32'h0000_0041, 4'b1110, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{"near_addr", 32'h9000_0018,  32'h0000_0042, 4'b0001, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{"putc_low8", PUTC,           32'hABCD_EF5A, 4'b0001, 1'b0, 1'b1, 8'h5A};

    idle_bus();
    tx_ready = 1'b0;
    do_reset();
    check_idle_outputs("reset");

    // Back-to-back 'H','i' stream out on consecutive cycles.
    tx_ready = 1'b1;
    drive_write(PUTC, 32'h48, 4'b0001);
    #1 check("hi ram_wready0", ram_wready, 0);
    tick();
    drive_write(PUTC, 32'h69, 4'b0001);
    #1 check("hi ram_wready1", ram_wready, 0);
    check("hi byte0", tx_data, 8'h48);
    tick();
    idle_bus();
    check("hi byte1", tx_data, 8'h69);
    check("hi valid1", tx_valid, 1);
    tick();
    check("hi empty", tx_valid, 0);

    // Decode table, one write per vector, result one cycle later.
    for (int i = 0; i < 6; i++) begin
      drive_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      #1 check({vecs[i].name, " ram_wready"}, ram_wready, vecs[i].exp_ram);
      tick();
      idle_bus();
      check({vecs[i].name, " tx_valid"}, tx_valid, vecs[i].exp_tx);
      check({vecs[i].name, " tx_data"}, tx_data, vecs[i].exp_tx ? vecs[i].exp_byte : 8'h00);
      tick();
    end
    check("table overflow_cnt", overflow_cnt, 0);

    // 20 writes into a stalled sink: 16 kept, 4 dropped.
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_write(PUTC, 32'h10 + i, 4'b0001);
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      tick();
      if (i == 12) check("stall after 13", stall_req, 0);
      if (i == 13) check("stall after 14", stall_req, 1);
    end
    idle_bus();
    check("fill overflow_cnt", overflow_cnt, 4);
    check("fill head", tx_data, 8'h10);

    // Full FIFO, push and pop in the same cycle.
    tx_ready = 1'b1;
    drive_write(PUTC, 32'h77, 4'b0001);
    #1 check("fullpush head", tx_data, exp_q.pop_front());
    exp_q.push_back(8'h77);
    tick();
    idle_bus();
    check("fullpush overflow_cnt", overflow_cnt, 4);
    check("fullpush stall", stall_req, 1);
    drain_expect("fill drain");
    check("fill drained valid", tx_valid, 0);
    check("fill drained stall", stall_req, 0);

    // Exit with 3 bytes pending.
    do_reset();
    check_idle_outputs("reset2");
    for (int i = 0; i < 3; i++) begin
      drive_write(PUTC, 32'hA1 + i, 4'b0001);
      exp_q.push_back(8'(8'hA1 + i));
      tick();
    end
    drive_write(EXIT, 32'd7, 4'b1111);
    #1 check("exit ram_wready", ram_wready, 0);
    tick();
    drive_write(PUTC, 32'hEE, 4'b0001);
    #1 check("drain putc ram_wready", ram_wready, 0);
    tick();
    drive_write(32'h0000_0100, 32'h5, 4'b1111);
    #1 check("drain ram_wready", ram_wready, 0);
    tick();
    idle_bus();
    check("drain exit_code", exit_code, 7);
    check("drain exit_valid", exit_valid, 0);
    check("drain stall", stall_req, 1);
    check("drain state", fsm_state, 1);
    check("drain overflow_cnt", overflow_cnt, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain byte", tx_data, exp_q.pop_front());
      tick();
    end
    check("drain empty", tx_valid, 0);
    check("drain exit_valid early", exit_valid, 0);
    tick();
    check("done exit_valid", exit_valid, 1);
    check("done state", fsm_state, 2);
    drive_write(32'h0000_0200, 32'h9, 4'b1111);
    #1 check("done ram_wready", ram_wready, 0);
    tick();
    idle_bus();
    check("done held", exit_valid, 1);

    // Asynchronous reset while draining 5 bytes.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_write(PUTC, 32'hC0 + i, 4'b0001);
      tick();
    end
    drive_write(EXIT, 32'h55, 4'b1111);
    tick();
    idle_bus();
    check("pre-reset state", fsm_state, 1);
    check("pre-reset exit_code", exit_code, 32'h55);
    check("pre-reset tx_data", tx_data, 8'hC0);
    #2 resetb = 1'b0;
    #1 check_idle_outputs("async");
    @(negedge clk);
    resetb = 1'b1;
    tick();
    check("post-reset state", fsm_state, 0);
    check("post-reset tx_valid", tx_valid, 0);
    drive_write(32'h0002_0000, 32'h1, 4'b1111);
    #1 check("post-reset ram_wready", ram_wready, 1);
    tick();

    // Exit with an empty FIFO.
    drive_write(EXIT, 32'd9, 4'b0001);
    tick();
    idle_bus();
    check("empty-exit valid n+1", exit_valid, 0);
    check("empty-exit code", exit_code, 9);
    tick();
    check("empty-exit valid n+2", exit_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
